// File: rtl/uart_rx_pkg.sv
// Shared constants and types for the UART receive peripheral.
// Holds the register map, register bit positions and the receiver FSM states.
package uart_rx_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERRUN   = 2;
    localparam int ST_FRAME_ERR = 3;

    localparam int CTRL_RX_EN  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_FLUSH  = 2;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    // The STATUS fill field is 4 bits wide, so deeper FIFOs show 15 when fuller.
    function automatic logic [3:0] sat_fill(input logic [31:0] n);
        return (n > 32'd15) ? 4'hF : n[3:0];
    endfunction

endpackage

// File: rtl/uart_rx_ip_sync_fifo.sv
// First-word-fall-through synchronous FIFO: dout shows the head entry whenever not empty.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop on the same cycle frees a slot, so a push into a full FIFO still lands.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_rx_ip.sv
// Memory-mapped 8N1 UART receiver: synchroniser, bit-timing FSM, receive FIFO and
// DATA/STATUS/CTRL registers on the SoC local bus.
module uart_rx_ip
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] waddr,
    input  logic [31:0] wdata,
    input  logic        wen,
    input  logic [3:0]  wstrb,
    output logic        wready,
    input  logic [31:0] raddr,
    input  logic        ren,
    output logic [31:0] rdata,
    output logic        rvalid,
    input  logic        i_uart_rx,
    output logic        o_irq
);

    localparam int BW  = $clog2(CLKS_PER_BIT);
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);

    logic            rx_meta, rx_s, rx_prev;
    rx_state_e       state;
    logic [BW-1:0]   baud_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            rx_en, irq_en, flush_r;
    logic            overrun, frame_err;
    logic            wr_status, wr_ctrl;
    logic            stop_tick, push_req, frame_bad, pop, overrun_set;
    logic [7:0]      fifo_dout;
    logic            fifo_empty, fifo_full;
    logic [FAW:0]    fifo_count;
    logic            unused_bits;

    assign unused_bits = ^{waddr[31:4], waddr[1:0], wdata[31:4], wstrb[3:1],
                           raddr[31:4], raddr[1:0]};

    // Idle-high reset value keeps the edge detector quiet coming out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= i_uart_rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RX_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else if (!rx_en) begin
            state    <= RX_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            case (state)
                RX_IDLE: begin
                    baud_cnt <= '0;
                    if (rx_prev && !rx_s) state <= RX_START;
                end
                RX_START: begin
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        shreg    <= {rx_s, shreg[7:1]};
                        if (bit_cnt == 3'd7) state <= RX_STOP;
                        else                 bit_cnt <= bit_cnt + 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        state    <= RX_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    assign stop_tick   = rx_en && (state == RX_STOP) && (baud_cnt == BAUD_LAST);
    assign push_req    = stop_tick & rx_s;
    assign frame_bad   = stop_tick & ~rx_s;
    assign pop         = ren && (raddr[3:2] == REG_DATA) && !fifo_empty;
    assign overrun_set = push_req & fifo_full & ~pop & ~flush_r;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (pop),
        .flush (flush_r),
        .din   (shreg),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign wr_status = wen && wstrb[0] && (waddr[3:2] == REG_STATUS);
    assign wr_ctrl   = wen && wstrb[0] && (waddr[3:2] == REG_CTRL);

    // Sticky bits: a hardware set on the same cycle as a write-1-to-clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_en     <= 1'b1;
            irq_en    <= 1'b0;
            flush_r   <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                rx_en  <= wdata[CTRL_RX_EN];
                irq_en <= wdata[CTRL_IRQ_EN];
            end
            flush_r <= wr_ctrl & wdata[CTRL_FLUSH];
            if (overrun_set)                        overrun <= 1'b1;
            else if (wr_status && wdata[ST_OVERRUN]) overrun <= 1'b0;
            if (frame_bad)                            frame_err <= 1'b1;
            else if (wr_status && wdata[ST_FRAME_ERR]) frame_err <= 1'b0;
        end
    end

    // Bus handshake: wready and rvalid are single-cycle pulses one cycle after
    // wen/ren; rdata is meaningful only while rvalid is high, and there is no stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            wready <= 1'b0;
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            wready <= wen;
            rvalid <= ren;
            if (ren) begin
                case (raddr[3:2])
                    REG_DATA:   rdata <= fifo_empty ? 32'd0 : {23'd0, 1'b1, fifo_dout};
                    REG_STATUS: rdata <= {24'd0, sat_fill(32'(fifo_count)), frame_err,
                                          overrun, fifo_full, ~fifo_empty};
                    REG_CTRL:   rdata <= {29'd0, flush_r, irq_en, rx_en};
                    default:    rdata <= 32'd0;
                endcase
            end
        end
    end

    assign o_irq = irq_en & ~fifo_empty;

endmodule

// File: tb/tb_uart_rx_ip.sv
// Directed bench for uart_rx_ip at 16 clocks per bit; inputs change and outputs
// are sampled on the falling clock edge.
module tb_uart_rx_ip;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] waddr, wdata, raddr;
    logic        wen, ren;
    logic [3:0]  wstrb;
    logic        wready, rvalid, i_uart_rx, o_irq;
    logic [31:0] rdata;
    logic [31:0] got;

    int chk_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    uart_rx_ip #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .waddr     (waddr),
        .wdata     (wdata),
        .wen       (wen),
        .wstrb     (wstrb),
        .wready    (wready),
        .raddr     (raddr),
        .ren       (ren),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .i_uart_rx (i_uart_rx),
        .o_irq     (o_irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] idx, input logic [31:0] data);
        @(negedge clk);
        wen = 1'b1; waddr = {28'd0, idx, 2'b00}; wdata = data; wstrb = 4'hF;
        @(negedge clk);
        wen = 1'b0;
        check("wready", {31'd0, wready}, 32'd1);
    endtask

    task automatic read_check(input string tag, input logic [1:0] idx, input logic [31:0] exp);
        @(negedge clk);
        ren = 1'b1; raddr = {28'd0, idx, 2'b00};
        @(negedge clk);
        ren = 1'b0;
        check({tag, "_rvalid"}, {31'd0, rvalid}, 32'd1);
        check(tag, rdata, exp);
    endtask

    // One 8N1 frame, LSB first; the line returns high afterwards.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, data, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            i_uart_rx = bits[i];
            repeat (CPB - 1) @(negedge clk);
        end
        @(negedge clk);
        i_uart_rx = 1'b1;
    endtask

    initial begin
        rst = 1'b1; i_uart_rx = 1'b1; wen = 1'b0; ren = 1'b0;
        waddr = '0; wdata = '0; wstrb = '0; raddr = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_rdata", rdata, 32'd0);
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_wready", {31'd0, wready}, 32'd0);
        check("rst_irq", {31'd0, o_irq}, 32'd0);
        read_check("rst_status", 2'd1, 32'h0);
        read_check("rst_ctrl", 2'd2, 32'h1);

        // Single byte, then empty read
        send_frame(8'hA5, 1'b1);
        read_check("data_a5", 2'd0, 32'h1A5);
        read_check("data_empty", 2'd0, 32'h0);
        read_check("status_idle", 2'd1, 32'h0);

        // Nine frames into an eight-entry FIFO
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1);
        read_check("status_full_ovr", 2'd1, 32'h87);
        for (int i = 1; i <= 8; i++) read_check("data_drain", 2'd0, 32'h100 + i);
        read_check("status_ovr_only", 2'd1, 32'h04);
        bus_write(2'd1, 32'h4);
        read_check("status_ovr_clr", 2'd1, 32'h0);

        // Framing error, then a clean frame
        send_frame(8'h3C, 1'b0);
        read_check("status_frame_err", 2'd1, 32'h08);
        bus_write(2'd1, 32'h8);
        read_check("status_ferr_clr", 2'd1, 32'h0);
        send_frame(8'h55, 1'b1);
        read_check("status_one", 2'd1, 32'h11);
        read_check("data_55", 2'd0, 32'h155);

        // Start-bit glitch shorter than half a bit
        @(negedge clk);
        i_uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        i_uart_rx = 1'b1;
        repeat (40) @(negedge clk);
        read_check("status_glitch", 2'd1, 32'h0);

        // Interrupt
        bus_write(2'd2, 32'h3);
        send_frame(8'h77, 1'b1);
        check("irq_set", {31'd0, o_irq}, 32'd1);
        read_check("data_77", 2'd0, 32'h177);
        check("irq_clr", {31'd0, o_irq}, 32'd0);

        // rx_en cleared mid-frame
        fork
            send_frame(8'h99, 1'b1);
            begin
                repeat (60) @(negedge clk);
                bus_write(2'd2, 32'h2);
            end
        join
        bus_write(2'd2, 32'h3);
        read_check("status_rxen_abort", 2'd1, 32'h0);
        read_check("ctrl_rw", 2'd2, 32'h3);

        // Reset mid-frame with a byte buffered and the interrupt enabled
        send_frame(8'h12, 1'b1);
        check("irq_before_rst", {31'd0, o_irq}, 32'd1);
        @(negedge clk);
        i_uart_rx = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1; i_uart_rx = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst2_rdata", rdata, 32'd0);
        check("rst2_irq", {31'd0, o_irq}, 32'd0);
        check("rst2_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst2_wready", {31'd0, wready}, 32'd0);
        read_check("rst2_status", 2'd1, 32'h0);
        read_check("rst2_ctrl", 2'd2, 32'h1);
        read_check("rst2_data", 2'd0, 32'h0);

        // Pop on the same cycle as the stop-bit push into a full FIFO
        for (int i = 1; i <= 8; i++) send_frame(8'(8'h20 + i), 1'b1);
        fork
            send_frame(8'h30, 1'b1);
            begin
                repeat (155) @(negedge clk);
                ren = 1'b1; raddr = 32'h0;
                @(negedge clk);
                ren = 1'b0;
                got = rdata;
                check("race_rvalid", {31'd0, rvalid}, 32'd1);
                check("race_data", got, 32'h121);
            end
        join
        read_check("status_race", 2'd1, 32'h83);
        read_check("data_after_race", 2'd0, 32'h122);
        read_check("status_seven", 2'd1, 32'h71);
        bus_write(2'd2, 32'h5);
        read_check("status_flushed", 2'd1, 32'h0);
        read_check("ctrl_flush_selfclr", 2'd2, 32'h1);
        read_check("data_flushed", 2'd0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/uart_rx_ip.md
Name: uart_rx_ip

Overview:
Memory-mapped UART receiver peripheral on the SoC local bus, the receive counterpart to the UART transmit peripheral. It deserialises 8N1 frames from the board RX pin and buffers them in a small FIFO. The processor reads bytes and status through the same local-bus protocol (waddr/wdata/wen/wstrb, raddr/ren/rdata/rvalid) used by the other peripherals. Device select and read-data muxing happen upstream at SoC level.

Parameters:
CLKS_PER_BIT, 104, clk cycles per UART bit (12 MHz / 115200); must be >= 4
FIFO_DEPTH, 8, receive FIFO entries; power of two, >= 2

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
waddr  in  32  write address; only waddr[3:2] decoded
wdata  in  32  write data
wen  in  1  write enable (already qualified by device select)
wstrb  in  4  byte strobes
wready  out  1  write accepted, pulses 1 cycle after wen
raddr  in  32  read address; only raddr[3:2] decoded
ren  in  1  read enable (already qualified by device select)
rdata  out  32  registered read data
rvalid  out  1  pulses 1 cycle after ren
i_uart_rx  in  1  asynchronous serial input, idle high
o_irq  out  1  level interrupt: CTRL.irq_en & FIFO not empty

Behaviour:
- Reset: rdata=0, rvalid=0, wready=0, o_irq=0, FIFO empty, STATUS sticky bits=0, CTRL=0x1 (rx_en=1, irq_en=0), FSM=IDLE, both synchroniser flops=1.
- i_uart_rx passes a 2-flop synchroniser; the FSM sees only the synchronised value rx_s.
- Registers (addr[3:2]):
  0 DATA (RO): [7:0] byte at FIFO head, [8] valid; a read with valid=1 pops. A read when empty returns 0 and does not pop.
  1 STATUS: [0] not_empty, [1] full, [2] overrun (sticky), [3] frame_err (sticky), [7:4] fill level (saturating display of count). Writing 1 to bit 2 or 3 with wstrb[0] clears that bit. Other bits are RO.
  2 CTRL (RW, wstrb[0] only): [0] rx_en, [1] irq_en, [2] flush (self-clearing; empties the FIFO next cycle).
  3: reads 0, writes ignored.
- Read latency: 1 cycle. rdata and rvalid register on the cycle after ren. Pop occurs on the ren cycle. Back-to-back ren on consecutive cycles each pop one entry.
- wready is wen delayed 1 cycle. Writes take effect on the edge where wen=1.
- FSM:
  IDLE: entered while rx_en=0 or after a frame. Moves to START on a 1->0 transition of rx_s. A line held low does not retrigger.
  START: wait CLKS_PER_BIT/2 cycles, then sample. If low, go to DATA with the bit counter at 0. If high, treat as a glitch and return to IDLE.
  DATA: every CLKS_PER_BIT cycles, sample one bit and shift it in LSB-first. After bit 7, go to STOP.
  STOP: after CLKS_PER_BIT cycles, sample. If high, push the byte. If low, set frame_err, discard the byte and return to IDLE.
- Push into a full FIFO: byte dropped, overrun set, contents unchanged.
- Pop and push on the same cycle: both occur and count is unchanged. When full, a simultaneous pop frees space, so the push succeeds with no overrun.
- Flush and push on the same cycle: flush wins and the pushed byte is lost (no overrun).
- rx_en cleared mid-frame: FSM returns to IDLE immediately, the partial byte is discarded and no error is flagged.
- Sticky-bit set and W1C on the same cycle: set wins.
- Width rules: bit counter is 3 bits. Baud counter is $clog2(CLKS_PER_BIT) bits, reloaded to 0 at each bit boundary. FIFO pointers are log2(FIFO_DEPTH)+1 bits so full and empty are distinguishable.

Decomposition:
- Package uart_rx_pkg holds:
  - register offset constants (DATA=0, STATUS=1, CTRL=2);
  - STATUS and CTRL bit-position constants;
  - FSM state enum (IDLE, START, DATA, STOP).
- One sub-module, sync_fifo: parameters WIDTH and DEPTH; ports push, pop, flush, din, dout, empty, full, count. The FIFO is first-word-fall-through so dout is valid whenever not empty.

Test Plan:
- Run with CLKS_PER_BIT=16. Send frame 0xA5, then read DATA -> rdata=0x1A5 one cycle after ren. Next DATA read -> 0x000. STATUS=0.
- Send 9 frames 0x01..0x09 with no reads -> STATUS[1]=1, STATUS[2]=1. The 8 DATA reads return 0x101..0x108. Write 0x4 to STATUS -> overrun=0.
- Send 0x3C with the stop bit driven low -> frame_err=1, FIFO empty. Next valid frame 0x55 is received correctly.
- Pulse RX low for 4 cycles (shorter than half a bit) -> FSM returns to IDLE, nothing pushed, no error.
- Set CTRL=0x3 and receive 0x77 -> o_irq=1. Read DATA -> o_irq=0 on the next cycle. Clear rx_en mid-frame -> no push. Assert rst mid-frame -> all reset values restored.
- With the FIFO full, issue a DATA read on the cycle the stop bit is sampled -> count stays at 8, no overrun. Then write CTRL flush -> STATUS[0]=0.
